ssd_display_arbiter: RTL

- Shares the 8-digit seven-segment display between up to NREQ requesters, e.g. CPU result register, UART RX byte, PC/debug value and trap cause.
- Round-robin arbitration with a valid/ready handshake per requester.
- Each granted value is held on the display for a fixed minimum time so a human can read it.
- Sits between the requesters and the seven-segment decoder; disp_data_o drives the decoder's data input.

---
 rtl/ssd_display_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/ssd_display_arbiter.sv
// ssd_display_arbiter
//   Shares one 8-digit seven-segment display between NREQ requesters.
//   Round-robin grant over a valid/ready handshake. Each accepted value is
//   held on the display for HOLD_CYCLES clocks so a human can read it.
//   disp_data_o feeds the seven-segment decoder's data input.
//
// Ports
//   clk, reset     : clock; synchronous active-high reset
//   req_valid      : per-requester request
//   req_data       : flattened values, requester i at [i*DW +: DW]
//   req_ready      : one-hot grant (combinational, 0 while reset is high)
//   disp_data_o    : value currently shown
//   disp_src_o     : index of the requester that owns disp_data_o
//   disp_valid_o   : a value has been accepted since reset
//   busy_o         : high while in HOLD
//
// Build option
//   SSD_ARB_PRIO_EN : requester 0 (trap cause) is high priority and may
//                     pre-empt a HOLD owned by any other requester.
module ssd_display_arbiter #(
    parameter int DW          = 32,
    parameter int NREQ        = 4,
    parameter int HOLD_CYCLES = 100000000,
    parameter int SW          = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic [DW-1:0]        disp_data_o,
    output logic [SW-1:0]        disp_src_o,
    output logic                 disp_valid_o,
    output logic                 busy_o
);

    localparam int HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [HCW-1:0] HOLD_INIT = HCW'(HOLD_CYCLES - 1);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t          state, state_nxt;
    logic [SW-1:0]   rr_ptr;
    logic [HCW-1:0]  hold_cnt;

    logic            lo_any, hi_any;
    logic [SW-1:0]   lo_idx, hi_idx;
    logic            grant_on;
    logic [SW-1:0]   grant_idx;
    logic [SW-1:0]   ptr_after;
    logic [DW-1:0]   grant_data;

    // Round-robin search without modulo arithmetic: the lowest valid index
    // at or above rr_ptr wins; otherwise wrap to the lowest valid index.
    // Scanning downward leaves the lowest match in each variable.
    always_comb begin
        lo_any = 1'b0;
        lo_idx = '0;
        hi_any = 1'b0;
        hi_idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                lo_any = 1'b1;
                lo_idx = SW'(i);
                if (SW'(i) >= rr_ptr) begin
                    hi_any = 1'b1;
                    hi_idx = SW'(i);
                end
            end
        end
    end

    // Next state and grant
    always_comb begin
        state_nxt = state;
        grant_on  = 1'b0;
        grant_idx = hi_any ? hi_idx : lo_idx;
        case (state)
            IDLE: begin
`ifdef SSD_ARB_PRIO_EN
                if (req_valid[0]) grant_idx = '0;
`endif
                if (lo_any) begin
                    grant_on  = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
`ifdef SSD_ARB_PRIO_EN
                // Trap pre-emption: restart the hold with requester 0's value.
                if (disp_src_o != '0 && req_valid[0]) begin
                    grant_on  = 1'b1;
                    grant_idx = '0;
                end else
`endif
                if (hold_cnt == '0) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (reset) grant_on = 1'b0;
    end

    always_comb begin
        req_ready  = '0;
        grant_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == SW'(i)) begin
                req_ready[i] = grant_on;
                grant_data   = req_data[i*DW +: DW];
            end
        end
    end

    // Explicit wrap keeps rr_ptr in range for non-power-of-2 NREQ.
    assign ptr_after = (grant_idx == SW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
    assign busy_o    = (state == HOLD);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            hold_cnt     <= '0;
            disp_data_o  <= '0;
            disp_src_o   <= '0;
            disp_valid_o <= 1'b0;
        end else begin
            state <= state_nxt;
            if (grant_on) begin
                disp_data_o  <= grant_data;
                disp_src_o   <= grant_idx;
                disp_valid_o <= 1'b1;
                hold_cnt     <= HOLD_INIT;
                rr_ptr       <= ptr_after;
            end else if (state == HOLD && hold_cnt != '0) begin
                hold_cnt <= hold_cnt - 1'b1;
            end
        end
    end

endmodule
